// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window controller.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } win_state_e;

  localparam int PIX_W_DEF = 10;

  // Tap slots in the window register; the centre pixel is not carried.
  localparam int NUM_TAPS = 8;
  localparam int TAP_P0   = 0;
  localparam int TAP_P1   = 1;
  localparam int TAP_P2   = 2;
  localparam int TAP_P3   = 3;
  localparam int TAP_P5   = 4;
  localparam int TAP_P6   = 5;
  localparam int TAP_P7   = 6;
  localparam int TAP_P8   = 7;

endpackage

// File: rtl/sobel_line_buf.sv
// Single-port line buffer: read-first, registered read data, plus the
// overwritten word presented combinationally so buffers can be cascaded.
module sobel_line_buf #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 10,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic [WIDTH-1:0]  old_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  assign old_o   = mem_q[addr_i];
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_q       <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel 3x3 window controller: raster pixel stream in, 8 neighbourhood taps out.
// Define SOBEL_BORDER_ZERO_EN to emit a window per pixel with off-frame taps forced to 0.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             i_sof,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_pix,
  output logic             o_ready,
  output logic [PIX_W-1:0] o_p0,
  output logic [PIX_W-1:0] o_p1,
  output logic [PIX_W-1:0] o_p2,
  output logic [PIX_W-1:0] o_p3,
  output logic [PIX_W-1:0] o_p5,
  output logic [PIX_W-1:0] o_p6,
  output logic [PIX_W-1:0] o_p7,
  output logic [PIX_W-1:0] o_p8,
  output logic             o_win_valid,
  input  logic             i_win_ready,
  output logic             o_eof,
  output logic             o_sof_err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  win_state_e       state_q, state_d;
  logic [CW-1:0]    c_q, c_d, pix_c;
  logic [RW-1:0]    r_q, r_d, pix_r;
  logic             xfer, accept, emit, is_last;
  logic [PIX_W-1:0] lb0_old, lb0_rdata, lb1_old, lb1_rdata;
  logic [PIX_W-1:0] a2_q, b2_q, c1_q, c2_q;
  logic [PIX_W-1:0] taps  [NUM_TAPS];
  logic [PIX_W-1:0] win_q [NUM_TAPS];
  logic [PIX_W-1:0] win_d [NUM_TAPS];
  logic             win_valid_q, win_valid_d;
  logic             eof_q, eof_d;
  logic             sof_err_q, sof_err_d;

  assign o_ready = !win_valid_q || i_win_ready;
  assign xfer    = i_valid && o_ready;
  assign accept  = xfer && (i_sof || (state_q != ST_IDLE));
  // A start-of-frame pixel is always (0,0), whatever the counters say.
  assign pix_c   = i_sof ? '0 : c_q;
  assign pix_r   = i_sof ? '0 : r_q;
  assign is_last = (pix_r == R_LAST) && (pix_c == C_LAST);

  // lb0 holds row r-1; its displaced word (row r-1) cascades into lb1 as row r-2.
  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(CW)) u_lb0 (
    .clk_i   (iCLK),
    .en_i    (accept),
    .addr_i  (pix_c),
    .wdata_i (i_pix),
    .rdata_o (lb0_rdata),
    .old_o   (lb0_old)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(CW)) u_lb1 (
    .clk_i   (iCLK),
    .en_i    (accept),
    .addr_i  (pix_c),
    .wdata_i (lb0_old),
    .rdata_o (lb1_rdata),
    .old_o   (lb1_old)
  );

  // Registered line-buffer reads already lag one column, so they serve as the c-1 taps.
  always_comb begin
    taps[TAP_P0] = a2_q;
    taps[TAP_P1] = lb1_rdata;
    taps[TAP_P2] = lb1_old;
    taps[TAP_P3] = b2_q;
    taps[TAP_P5] = lb0_old;
    taps[TAP_P6] = c2_q;
    taps[TAP_P7] = c1_q;
    taps[TAP_P8] = i_pix;
`ifdef SOBEL_BORDER_ZERO_EN
    if (pix_r < RW'(2)) begin
      taps[TAP_P0] = '0;
      taps[TAP_P1] = '0;
      taps[TAP_P2] = '0;
    end
    if (pix_r == '0) begin
      taps[TAP_P3] = '0;
      taps[TAP_P5] = '0;
    end
    if (pix_c < CW'(2)) begin
      taps[TAP_P0] = '0;
      taps[TAP_P3] = '0;
      taps[TAP_P6] = '0;
    end
    if (pix_c == '0) begin
      taps[TAP_P1] = '0;
      taps[TAP_P7] = '0;
    end
    emit = accept;
`else
    emit = accept && (pix_r >= RW'(2)) && (pix_c >= CW'(2));
`endif
  end

  always_comb begin
    state_d   = state_q;
    sof_err_d = 1'b0;
    c_d       = c_q;
    r_d       = r_q;
    if (accept) begin
      if (pix_c == C_LAST) begin
        c_d = '0;
        r_d = (pix_r == R_LAST) ? '0 : pix_r + 1'b1;
      end else begin
        c_d = pix_c + 1'b1;
        r_d = pix_r;
      end
      if (i_sof) begin
        state_d   = ST_FILL;
        sof_err_d = (state_q != ST_IDLE);
      end else begin
        case (state_q)
          ST_FILL: if ((pix_r == RW'(2)) && (pix_c == '0)) state_d = ST_RUN;
          ST_RUN:  if (is_last) state_d = ST_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Loading only happens when o_ready is high, so an unaccepted window is never overwritten.
  always_comb begin
    win_d       = win_q;
    win_valid_d = win_valid_q;
    eof_d       = eof_q;
    if (emit) begin
      win_d       = taps;
      win_valid_d = 1'b1;
      eof_d       = is_last;
    end else if (i_win_ready) begin
      win_valid_d = 1'b0;
      eof_d       = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      c_q         <= '0;
      r_q         <= '0;
      win_valid_q <= 1'b0;
      eof_q       <= 1'b0;
      sof_err_q   <= 1'b0;
      a2_q        <= '0;
      b2_q        <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      for (int i = 0; i < NUM_TAPS; i++) win_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      win_valid_q <= win_valid_d;
      eof_q       <= eof_d;
      sof_err_q   <= sof_err_d;
      win_q       <= win_d;
      if (accept) begin
        a2_q <= lb1_rdata;
        b2_q <= lb0_rdata;
        c2_q <= c1_q;
        c1_q <= i_pix;
      end
    end
  end

  assign o_p0        = win_q[TAP_P0];
  assign o_p1        = win_q[TAP_P1];
  assign o_p2        = win_q[TAP_P2];
  assign o_p3        = win_q[TAP_P3];
  assign o_p5        = win_q[TAP_P5];
  assign o_p6        = win_q[TAP_P6];
  assign o_p7        = win_q[TAP_P7];
  assign o_p8        = win_q[TAP_P8];
  assign o_win_valid = win_valid_q;
  assign o_eof       = eof_q;
  assign o_sof_err   = sof_err_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a 4x4 image; follows SOBEL_BORDER_ZERO_EN.
module tb_sobel_window_ctrl;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int PIX_W = 10;
`ifdef SOBEL_BORDER_ZERO_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  localparam int NWIN = BORDER ? IMG_W * IMG_H : (IMG_W - 2) * (IMG_H - 2);

  logic             iCLK = 1'b0;
  logic             iRST_N = 1'b0;
  logic             i_sof = 1'b0;
  logic             i_valid = 1'b0;
  logic [PIX_W-1:0] i_pix = '0;
  logic             i_win_ready = 1'b1;
  logic             o_ready, o_win_valid, o_eof, o_sof_err;
  logic [PIX_W-1:0] o_p0, o_p1, o_p2, o_p3, o_p5, o_p6, o_p7, o_p8;
  logic [8*PIX_W-1:0] dutTaps;

  typedef struct packed {
    logic [8*PIX_W-1:0] taps;
    logic               eof;
  } expWin_t;

  expWin_t          sb[$];
  logic [PIX_W-1:0] img [IMG_H][IMG_W];
  int  mR = 0, mC = 0;
  bit  mActive = 1'b0;
  int  compared = 0, mismatched = 0;
  int  winSeen = 0, eofSeen = 0, sofErrSeen = 0, expSofErr = 0;

  sobel_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .i_sof       (i_sof),
    .i_valid     (i_valid),
    .i_pix       (i_pix),
    .o_ready     (o_ready),
    .o_p0        (o_p0),
    .o_p1        (o_p1),
    .o_p2        (o_p2),
    .o_p3        (o_p3),
    .o_p5        (o_p5),
    .o_p6        (o_p6),
    .o_p7        (o_p7),
    .o_p8        (o_p8),
    .o_win_valid (o_win_valid),
    .i_win_ready (i_win_ready),
    .o_eof       (o_eof),
    .o_sof_err   (o_sof_err)
  );

  assign dutTaps = {o_p0, o_p1, o_p2, o_p3, o_p5, o_p6, o_p7, o_p8};

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] tapVal(int r, int c);
    if (r < 0 || c < 0) return '0;
    return img[r][c];
  endfunction

  // Coordinate-level reference: taps come straight from the stored image.
  task automatic modelAccept(input logic [PIX_W-1:0] pix, input logic sof);
    expWin_t e;
    if (!(sof || mActive)) return;
    if (sof) begin
      if (mActive) expSofErr++;
      mR = 0;
      mC = 0;
      mActive = 1'b1;
    end
    img[mR][mC] = pix;
    if (BORDER || (mR >= 2 && mC >= 2)) begin
      e.taps = {tapVal(mR-2, mC-2), tapVal(mR-2, mC-1), tapVal(mR-2, mC),
                tapVal(mR-1, mC-2), tapVal(mR-1, mC),
                tapVal(mR, mC-2), tapVal(mR, mC-1), tapVal(mR, mC)};
      e.eof  = (mR == IMG_H-1) && (mC == IMG_W-1);
      sb.push_back(e);
    end
    if (mC == IMG_W-1) begin
      mC = 0;
      if (mR == IMG_H-1) begin
        mR = 0;
        mActive = 1'b0;
      end else mR++;
    end else mC++;
  endtask

  task automatic applyStimulus(input logic [PIX_W-1:0] pix, input logic sof);
    int waitCnt;
    @(negedge iCLK);
    i_valid = 1'b1;
    i_pix   = pix;
    i_sof   = sof;
    #1;
    waitCnt = 0;
    while (!o_ready && waitCnt < 100) begin
      @(negedge iCLK);
      #1;
      waitCnt++;
    end
    if (!o_ready) begin
      checkOutput("ready_timeout", o_ready, 1);
      i_valid = 1'b0;
      i_sof   = 1'b0;
      return;
    end
    @(posedge iCLK);
    modelAccept(pix, sof);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic sendFrame(input int base);
    for (int i = 0; i < IMG_W * IMG_H; i++) applyStimulus(PIX_W'(base + i), i == 0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    do begin
      @(negedge iCLK);
      #3;
      n++;
    end while ((sb.size() != 0 || o_win_valid) && n < 60);
    checkOutput("drain_queue", sb.size(), 0);
  endtask

  task automatic pulseReset();
    @(negedge iCLK);
    iRST_N  = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    @(posedge iCLK);
    #1;
    sb.delete();
    mActive = 1'b0;
    mR = 0;
    mC = 0;
    checkOutput("rst_taps", dutTaps, 0);
    checkOutput("rst_win_valid", o_win_valid, 0);
    checkOutput("rst_eof", o_eof, 0);
    checkOutput("rst_sof_err", o_sof_err, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    checkOutput("rst_ready", o_ready, 1);
  endtask

  // Monitor: every presented window must match the queue head; pop on handshake.
  always begin
    @(negedge iCLK);
    #2;
    if (iRST_N && o_win_valid) begin
      if (sb.size() == 0) checkOutput("unexpected_window", o_win_valid, 0);
      else begin
        checkOutput("win_taps", dutTaps, sb[0].taps);
        checkOutput("win_eof", o_eof, sb[0].eof);
        if (i_win_ready) begin
          void'(sb.pop_front());
          winSeen++;
          if (o_eof) eofSeen++;
        end
      end
    end
    if (iRST_N && o_sof_err) sofErrSeen++;
  end

  initial begin
    #400000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, e0, s0;
    repeat (3) @(posedge iCLK);
    #1;
    checkOutput("init_taps", dutTaps, 0);
    checkOutput("init_win_valid", o_win_valid, 0);
    checkOutput("init_eof", o_eof, 0);
    checkOutput("init_sof_err", o_sof_err, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    checkOutput("init_ready", o_ready, 1);

    $display("[TB] basic frame 0..15");
    w0 = winSeen; e0 = eofSeen;
    sendFrame(0);
    waitDrain();
    checkOutput("basic_win_count", winSeen - w0, NWIN);
    checkOutput("basic_eof_count", eofSeen - e0, 1);

    $display("[TB] downstream stall");
    w0 = winSeen; e0 = eofSeen;
    @(negedge iCLK);
    i_win_ready = 1'b0;
    fork
      sendFrame(20);
      begin : stallProc
        int n;
        n = 0;
        while (!o_win_valid && n < 200) begin
          @(negedge iCLK);
          #1;
          n++;
        end
        checkOutput("stall_valid_seen", o_win_valid, 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge iCLK);
          #1;
          checkOutput("stall_ready_low", o_ready, 0);
          checkOutput("stall_valid_held", o_win_valid, 1);
        end
        @(negedge iCLK);
        i_win_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("stall_win_count", winSeen - w0, NWIN);
    checkOutput("stall_eof_count", eofSeen - e0, 1);

    $display("[TB] start-of-frame mid-frame");
    w0 = winSeen; s0 = sofErrSeen;
    for (int i = 0; i < 9; i++) applyStimulus(PIX_W'(100 + i), i == 0);
    sendFrame(0);
    waitDrain();
    checkOutput("soferr_pulses", sofErrSeen - s0, 1);
    checkOutput("soferr_win_count", winSeen - w0, NWIN + (BORDER ? 9 : 0));

    $display("[TB] reset mid-run");
    for (int i = 0; i < 11; i++) applyStimulus(PIX_W'(40 + i), i == 0);
    pulseReset();
    w0 = winSeen; s0 = sofErrSeen;
    for (int i = 0; i < 6; i++) applyStimulus(PIX_W'(60 + i), 1'b0);
    waitDrain();
    checkOutput("discard_win_count", winSeen - w0, 0);
    checkOutput("discard_sof_err", sofErrSeen - s0, 0);

    $display("[TB] back-to-back frames");
    w0 = winSeen; e0 = eofSeen; s0 = sofErrSeen;
    sendFrame(200);
    sendFrame(300);
    waitDrain();
    checkOutput("b2b_win_count", winSeen - w0, 2 * NWIN);
    checkOutput("b2b_eof_count", eofSeen - e0, 2);
    checkOutput("b2b_sof_err", sofErrSeen - s0, 0);

    checkOutput("sof_err_total", sofErrSeen, expSofErr);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
